// File: rtl/cfg_arb_pkg.sv
// ---------------------------------------------------------------------------
// cfg_arb_pkg
// Shared definitions for the config-memory port arbiter:
//   op_t       - per-requester operation encoding (2 bits)
//   state_t    - arbiter FSM states
//   LAT_*      - response latency in cycles, counted from the accept cycle
//   rmw_merge  - bit-masked merge used by read-modify-write
//   id_onehot  - requester id to rsp_valid pulse pattern
// ---------------------------------------------------------------------------
package cfg_arb_pkg;

    typedef enum logic [1:0] {
        OP_READ    = 2'b00,
        OP_WRITE   = 2'b01,
        OP_RMW     = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_WR    = 2'b11
    } state_t;

    // Accept happens in cycle 0; rsp_valid is high in cycle LAT_*.
    localparam int LAT_READ  = 3;
    localparam int LAT_WRITE = 2;
    localparam int LAT_RMW   = 4;
    localparam int LAT_ERR   = 2;

    // Mask bit 1 takes the new data bit, mask bit 0 keeps the old one.
    function automatic logic [31:0] rmw_merge(
        input logic [31:0] old_data,
        input logic [31:0] new_data,
        input logic [31:0] mask
    );
        return (old_data & ~mask) | (new_data & mask);
    endfunction

    function automatic logic [1:0] id_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin selector.
//   system_clk   in   clock
//   system_rstn  in   synchronous active-low reset (requester 0 gets priority)
//   valid[1:0]   in   request valid per requester
//   advance      in   a grant was taken this cycle; hand priority to the other
//   grant[1:0]   out  combinational one-hot grant (00 when nothing is valid)
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic       system_clk,
    input  logic       system_rstn,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    // prio_reg names the requester that wins a tie.
    logic prio_reg;

    always_comb begin
        grant = 2'b00;
        if (valid == 2'b11) begin
            grant = prio_reg ? 2'b10 : 2'b01;
        end else begin
            grant = valid;
        end
    end

    // After serving requester i the other one gets the tie-break.
    always_ff @(posedge system_clk) begin
        if (!system_rstn) begin
            prio_reg <= 1'b0;
        end else if (advance) begin
            prio_reg <= grant[0];
        end
    end

endmodule

// File: rtl/config_mem_port_arb.sv
// ---------------------------------------------------------------------------
// config_mem_port_arb
// Serialises read / write / read-modify-write requests from two requesters
// onto the system-side port of the configuration memory.
//
// Parameters: K = memory depth in words, D = address width.
// Ports:
//   system_clk, system_rstn    clock, synchronous active-low reset
//   req_valid/req_ready[1:0]   per-requester handshake (ready is combinational)
//   req_op[3:0]                2 bits per requester: read/write/rmw/illegal
//   req_addr[2*D-1:0]          word address per requester
//   req_wdata/req_mask[63:0]   32-bit write data / RMW mask per requester
//   cfg_lock                   config loader owns the memory; no new grants
//   rsp_valid[1:0]             one-cycle response pulse per requester
//   rsp_rdata, rsp_err         shared response data / error flag
//   mem_rdaddr, mem_rd_en,     memory address and strobes; memory returns
//   mem_wr_en, mem_wr_data,    mem_rd_data one cycle after mem_rd_en
//   mem_rd_data
//
// All outputs except req_ready are registers; a strobe register is set on
// the edge that enters the state that owns it, so it is visible during
// that state and is cleared by default on the next edge.
// ---------------------------------------------------------------------------
module config_mem_port_arb
    import cfg_arb_pkg::*;
#(
    parameter int K = 64,
    parameter int D = 6
) (
    input  logic           system_clk,
    input  logic           system_rstn,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [3:0]     req_op,
    input  logic [2*D-1:0] req_addr,
    input  logic [63:0]    req_wdata,
    input  logic [63:0]    req_mask,
    input  logic           cfg_lock,
    output logic [1:0]     rsp_valid,
    output logic [31:0]    rsp_rdata,
    output logic           rsp_err,
    output logic [D-1:0]   mem_rdaddr,
    output logic           mem_rd_en,
    output logic           mem_wr_en,
    output logic [31:0]    mem_wr_data,
    input  logic [31:0]    mem_rd_data
);

    // ---------------- per-requester field views ----------------
    op_t         op_arr    [2];
    logic [D-1:0] addr_arr [2];
    logic [31:0] wdata_arr [2];
    logic [31:0] mask_arr  [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
        assign op_arr[gi]    = op_t'(req_op[2*gi +: 2]);
        assign addr_arr[gi]  = req_addr[D*gi +: D];
        assign wdata_arr[gi] = req_wdata[32*gi +: 32];
        assign mask_arr[gi]  = req_mask[32*gi +: 32];
    end

    // ---------------- state / latched request ----------------
    state_t       state_reg;
    op_t          op_reg;
    logic [D-1:0] addr_reg;
    logic [31:0]  wdata_reg;
    logic [31:0]  mask_reg;
    logic         id_reg;
    logic         bad_reg;
    logic [31:0]  old_reg;

    // ---------------- arbitration ----------------
    logic [1:0] grant;
    logic       arb_open;
    logic       accept;

    assign arb_open  = (state_reg == ST_IDLE) && !cfg_lock;
    assign req_ready = arb_open ? grant : 2'b00;
    assign accept    = |req_ready;

    rr_arb2 u_rr_arb2 (
        .system_clk  (system_clk),
        .system_rstn (system_rstn),
        .valid       (req_valid),
        .advance     (accept),
        .grant       (grant)
    );

    // Selected requester's fields (valid only while accept is high).
    logic         sel_id;
    op_t          sel_op;
    logic [D-1:0] sel_addr;
    logic         sel_bad;

    assign sel_id   = grant[1];
    assign sel_op   = op_arr[sel_id];
    assign sel_addr = addr_arr[sel_id];
    // Out-of-range check is done at full integer width so that K == 2**D
    // (every address legal) works without overflow.
    assign sel_bad  = (sel_op == OP_ILLEGAL) || (32'(sel_addr) >= K);

    // ---------------- FSM and registered outputs ----------------
    always_ff @(posedge system_clk) begin
        if (!system_rstn) begin
            state_reg   <= ST_IDLE;
            op_reg      <= OP_READ;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            mask_reg    <= '0;
            id_reg      <= 1'b0;
            bad_reg     <= 1'b0;
            old_reg     <= '0;
            rsp_valid   <= 2'b00;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            mem_rdaddr  <= '0;
            mem_rd_en   <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_wr_data <= '0;
        end else begin
            // Pulses default low so each lasts exactly one cycle.
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            rsp_valid <= 2'b00;
            rsp_err   <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        op_reg     <= sel_op;
                        addr_reg   <= sel_addr;
                        wdata_reg  <= wdata_arr[sel_id];
                        mask_reg   <= mask_arr[sel_id];
                        id_reg     <= sel_id;
                        bad_reg    <= sel_bad;
                        mem_rdaddr <= sel_addr;
                        // The ISSUE-cycle strobe is launched here so that it
                        // is a register output during ISSUE.
                        if (!sel_bad) begin
                            if (sel_op == OP_WRITE) begin
                                mem_wr_en   <= 1'b1;
                                mem_wr_data <= wdata_arr[sel_id];
                            end else begin
                                mem_rd_en <= 1'b1;
                            end
                        end
                        state_reg <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (bad_reg || op_reg == OP_WRITE) begin
                        rsp_valid <= id_onehot(id_reg);
                        rsp_rdata <= '0;
                        rsp_err   <= bad_reg;
                        state_reg <= ST_IDLE;
                    end else begin
                        state_reg <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    // mem_rd_data is valid now (one cycle after the strobe).
                    if (op_reg == OP_RMW) begin
                        old_reg     <= mem_rd_data;
                        mem_rdaddr  <= addr_reg;
                        mem_wr_en   <= 1'b1;
                        mem_wr_data <= rmw_merge(mem_rd_data, wdata_reg, mask_reg);
                        state_reg   <= ST_WR;
                    end else begin
                        rsp_valid <= id_onehot(id_reg);
                        rsp_rdata <= mem_rd_data;
                        state_reg <= ST_IDLE;
                    end
                end

                ST_WR: begin
                    rsp_valid <= id_onehot(id_reg);
                    rsp_rdata <= old_reg;
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_config_mem_port_arb.sv
// ---------------------------------------------------------------------------
// tb_config_mem_port_arb
// Directed bench for config_mem_port_arb with K=48, D=6 and a behavioural
// memory that returns read data one cycle after mem_rd_en.
// Inputs are driven and outputs sampled around the falling clock edge.
// ---------------------------------------------------------------------------
module tb_config_mem_port_arb;

    logic        system_clk = 1'b0;
    logic        system_rstn;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req_op;
    logic [11:0] req_addr;
    logic [63:0] req_wdata;
    logic [63:0] req_mask;
    logic        cfg_lock;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [5:0]  mem_rdaddr;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;

    int tests = 0;
    int fails = 0;

    always #5 system_clk = ~system_clk;

    config_mem_port_arb #(.K(48), .D(6)) dut (
        .system_clk  (system_clk),
        .system_rstn (system_rstn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_mask    (req_mask),
        .cfg_lock    (cfg_lock),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .mem_rdaddr  (mem_rdaddr),
        .mem_rd_en   (mem_rd_en),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data)
    );

    // ---------------- memory model and strobe monitor ----------------
    logic [31:0] mem [0:47];
    int rd_cnt = 0;
    int wr_cnt = 0;
    int overlap_cnt = 0;
    int long_cnt = 0;
    logic prev_rd = 1'b0;
    logic prev_wr = 1'b0;

    always @(posedge system_clk) begin
        if (mem_rd_en) begin
            mem_rd_data <= (mem_rdaddr < 6'd48) ? mem[mem_rdaddr] : 32'hBAD0_BAD0;
            rd_cnt++;
        end
        if (mem_wr_en) begin
            if (mem_rdaddr < 6'd48) mem[mem_rdaddr] = mem_wr_data;
            wr_cnt++;
        end
        if (mem_rd_en && mem_wr_en) overlap_cnt++;
        if ((mem_rd_en && prev_rd) || (mem_wr_en && prev_wr)) long_cnt++;
        prev_rd = mem_rd_en;
        prev_wr = mem_wr_en;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request from requester id while the other is idle, then
    // follow it to its response and check latency and response fields.
    task automatic do_op(input string tag, input int id, input logic [1:0] op,
                         input logic [5:0] addr, input logic [31:0] wd,
                         input logic [31:0] mk, input int exp_lat,
                         input logic [31:0] exp_rd, input logic exp_err);
        int lat;
        logic [1:0] exp_v;
        exp_v = (id == 1) ? 2'b10 : 2'b01;
        req_op[2*id +: 2]     = op;
        req_addr[6*id +: 6]   = addr;
        req_wdata[32*id +: 32] = wd;
        req_mask[32*id +: 32]  = mk;
        req_valid = exp_v;
        #1;
        chk({tag, "_ready"}, req_ready, exp_v);
        @(negedge system_clk);
        req_valid = 2'b00;
        lat = 1;
        while (rsp_valid == 2'b00 && lat < 12) begin
            @(negedge system_clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_rsp_valid"}, rsp_valid, exp_v);
        chk({tag, "_rdata"}, rsp_rdata, exp_rd);
        chk({tag, "_err"}, rsp_err, exp_err);
        $display("[TB] %s: req%0d op=%0b addr=%0d lat=%0d rdata=%08h err=%0b",
                 tag, id, op, addr, lat, rsp_rdata, rsp_err);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int rd0, wr0, nz, ng, cyc;
        logic [1:0] grants [4];

        for (int i = 0; i < 48; i++) mem[i] = 32'h0;
        mem[5] = 32'hA5A5_0001;
        mem[2] = 32'hFFFF_0000;

        system_rstn = 1'b0;
        req_valid   = 2'b00;
        req_op      = '0;
        req_addr    = '0;
        req_wdata   = '0;
        req_mask    = '0;
        cfg_lock    = 1'b0;
        repeat (3) @(negedge system_clk);

        // Reset state
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_err", rsp_err, 1'b0);
        chk("rst_strobes", {mem_rd_en, mem_wr_en}, 2'b00);
        chk("rst_addr", mem_rdaddr, 6'd0);
        system_rstn = 1'b1;
        @(negedge system_clk);

        // Basic read, RMW, readbacks and write
        do_op("read5", 0, 2'b00, 6'd5, 32'h0, 32'h0, 3, 32'hA5A5_0001, 1'b0);
        do_op("rmw2", 1, 2'b10, 6'd2, 32'h0000_1234, 32'h0000_FFFF, 4, 32'hFFFF_0000, 1'b0);
        chk("rmw2_mem", mem[2], 32'hFFFF_1234);
        do_op("read2", 0, 2'b00, 6'd2, 32'h0, 32'h0, 3, 32'hFFFF_1234, 1'b0);
        do_op("write7", 0, 2'b01, 6'd7, 32'hDEAD_BEEF, 32'h0, 2, 32'h0, 1'b0);
        chk("write7_mem", mem[7], 32'hDEAD_BEEF);
        do_op("read7", 1, 2'b00, 6'd7, 32'h0, 32'h0, 3, 32'hDEAD_BEEF, 1'b0);

        // Error responses make no memory access
        rd0 = rd_cnt; wr0 = wr_cnt;
        do_op("illegal_op", 1, 2'b11, 6'd3, 32'h5555_5555, 32'h0, 2, 32'h0, 1'b1);
        chk("illegal_op_strobes", (rd_cnt - rd0) + (wr_cnt - wr0), 0);
        rd0 = rd_cnt; wr0 = wr_cnt;
        do_op("addr_eq_k", 0, 2'b01, 6'd48, 32'h1111_2222, 32'h0, 2, 32'h0, 1'b1);
        chk("addr_eq_k_strobes", (rd_cnt - rd0) + (wr_cnt - wr0), 0);
        do_op("last_word", 0, 2'b00, 6'd47, 32'h0, 32'h0, 3, 32'h0, 1'b0);

        // Lock: no grants while held, grant when dropped, and a lock raised
        // during WAIT does not abort the read.
        cfg_lock = 1'b1;
        req_op[1:0] = 2'b00;
        req_addr[5:0] = 6'd5;
        req_valid = 2'b01;
        nz = 0;
        repeat (10) begin
            #1;
            if (req_ready != 2'b00) nz++;
            @(negedge system_clk);
        end
        chk("lock_hold_ready_cycles", nz, 0);
        cfg_lock = 1'b0;
        #1;
        chk("lock_drop_ready", req_ready, 2'b01);
        @(negedge system_clk);
        req_valid = 2'b00;
        @(negedge system_clk);
        cfg_lock = 1'b1;
        @(negedge system_clk);
        chk("lock_wait_rsp_valid", rsp_valid, 2'b01);
        chk("lock_wait_rdata", rsp_rdata, 32'hA5A5_0001);
        req_valid = 2'b10;
        #1;
        chk("lock_idle_ready", req_ready, 2'b00);
        @(negedge system_clk);
        chk("lock_idle_ready2", req_ready, 2'b00);
        req_valid = 2'b00;
        cfg_lock = 1'b0;
        $display("[TB] lock: hold, release and lock-in-WAIT sequence done");
        @(negedge system_clk);

        // Reset during WAIT drops the read
        req_op[1:0] = 2'b00;
        req_addr[5:0] = 6'd5;
        req_valid = 2'b01;
        #1;
        chk("rstwait_ready", req_ready, 2'b01);
        @(negedge system_clk);
        req_valid = 2'b00;
        @(negedge system_clk);
        system_rstn = 1'b0;
        @(negedge system_clk);
        chk("rstwait_rsp_valid", rsp_valid, 2'b00);
        chk("rstwait_strobes", {mem_rd_en, mem_wr_en}, 2'b00);
        chk("rstwait_addr", mem_rdaddr, 6'd0);
        chk("rstwait_wdata", mem_wr_data, 32'h0);
        chk("rstwait_rdata", rsp_rdata, 32'h0);
        system_rstn = 1'b1;
        nz = 0;
        repeat (5) begin
            @(negedge system_clk);
            if (rsp_valid != 2'b00) nz++;
        end
        chk("rstwait_no_rsp", nz, 0);
        $display("[TB] reset in WAIT: response dropped");

        // Contention: both requesters write continuously; grants alternate
        // starting with requester 0.
        req_op    = 4'b0101;
        req_addr  = {6'd11, 6'd10};
        req_wdata = {32'h0000_0111, 32'h0000_0100};
        req_valid = 2'b11;
        ng = 0;
        cyc = 0;
        while (ng < 4 && cyc < 20) begin
            #1;
            if (req_ready != 2'b00) begin
                grants[ng] = req_ready;
                $display("[TB] contention: grant %0d = %02b", ng, req_ready);
                ng++;
            end
            @(negedge system_clk);
            cyc++;
        end
        req_valid = 2'b00;
        chk("cont_grant_count", ng, 4);
        chk("cont_grant0", grants[0], 2'b01);
        chk("cont_grant1", grants[1], 2'b10);
        chk("cont_grant2", grants[2], 2'b01);
        chk("cont_grant3", grants[3], 2'b10);
        repeat (4) @(negedge system_clk);
        chk("cont_mem10", mem[10], 32'h0000_0100);
        chk("cont_mem11", mem[11], 32'h0000_0111);
        chk("strobe_overlap", overlap_cnt, 0);
        chk("strobe_length", long_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/config_mem_port_arb.md
CONFIG_MEM_PORT_ARB -- requirements
Module: config_mem_port_arb

Interface
REQ-001 SHALL have parameter K, default 64, meaning config memory depth in words.
REQ-002 SHALL have parameter D, default 6, meaning address width.
REQ-003 system_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 system_rstn  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  2  per-requester request valid (bit i = requester i).
REQ-006 req_ready  output  2  per-requester accept; transfer when valid&ready in the same cycle.
REQ-007 req_op  input  4  2 bits per requester: 00 read, 01 write, 10 read-modify-write (RMW), 11 illegal.
REQ-008 req_addr  input  2*D  word address per requester.
REQ-009 req_wdata  input  64  32-bit write data per requester.
REQ-010 req_mask  input  64  32-bit RMW bit mask per requester (1 = take wdata bit).
REQ-011 cfg_lock  input  1  high while the config-mode APB load owns the memory; blocks new grants.
REQ-012 rsp_valid  output  2  one-cycle response pulse to requester i.
REQ-013 rsp_rdata  output  32  read data, or old data for RMW; shared, qualified by rsp_valid.
REQ-014 rsp_err  output  1  error flag, qualified by rsp_valid.
REQ-015 mem_rdaddr  output  D  memory system-side address.
REQ-016 mem_rd_en, mem_wr_en  output  1 each  memory read and write strobes.
REQ-017 mem_wr_data  output  32  memory write data.
REQ-018 mem_rd_data  input  32  memory read data, registered by the memory one cycle after mem_rd_en.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT and WR.
REQ-020 In IDLE with cfg_lock=0, req_ready SHALL be asserted combinationally for exactly one valid requester; other states or cfg_lock=1 SHALL give req_ready=0.
REQ-021 Arbitration SHALL be round-robin: after an accept from requester i, requester 1-i SHALL have priority; a lone valid requester SHALL always win.
REQ-022 On accept, op, addr, wdata, mask and requester id SHALL be latched, and the FSM SHALL go to ISSUE.
REQ-023 Illegal op or addr>=K: SHALL make no memory access, SHALL return rsp_valid, rsp_err=1 and rsp_rdata=0 in the cycle after ISSUE, then return to IDLE.
REQ-024 Read: ISSUE SHALL drive mem_rd_en=1; WAIT SHALL capture mem_rd_data; rsp_valid SHALL pulse in the next cycle; accept in cycle 0 gives response in cycle 3.
REQ-025 Write: ISSUE SHALL drive mem_wr_en=1 with the latched data; rsp_valid SHALL pulse in cycle 2 with rsp_rdata=0; the FSM SHALL then return to IDLE.
REQ-026 RMW: ISSUE SHALL read, and WAIT SHALL compute new=(old&~mask)|(wdata&mask).
REQ-027 RMW: WR SHALL drive mem_wr_en with new; the response SHALL come in cycle 4 with rsp_rdata=old.
REQ-028 mem_rd_en and mem_wr_en SHALL never be high together; each strobe SHALL last exactly one cycle.
REQ-029 All outputs except req_ready SHALL be registered; rsp_err SHALL be 0 on non-error responses.
REQ-030 cfg_lock rising mid-operation SHALL NOT abort it; the operation SHALL complete and the next grant SHALL wait for cfg_lock=0.
REQ-031 A new accept SHALL be possible in the same cycle as the previous rsp_valid pulse (the FSM is back in IDLE).
REQ-032 Requests SHALL be fully serialized; back-to-back same-address operations SHALL observe each other's writes.

Reset
REQ-033 system_rstn=0 at an edge SHALL force IDLE and give requester 0 priority.
REQ-034 system_rstn=0 at an edge SHALL zero all outputs and latched fields.
REQ-035 An in-flight operation hit by reset SHALL be dropped with no response; a strobe already issued is not recalled.

Structure
REQ-036 Package cfg_arb_pkg SHALL hold the op encodings, the FSM state enum and the response-latency constants.
REQ-037 Round-robin selection SHALL be sub-module rr_arb2: inputs valid[1:0] and advance, output grant[1:0] one-hot; it holds the priority pointer.

Verification
REQ-038 Read: mem[5]=0xA5A5_0001; req0 read addr 5 -> rsp_valid[0] 3 cycles after accept, rdata=0xA5A5_0001, err=0.
REQ-039 RMW: mem[2]=0xFFFF_0000; req1 RMW wdata=0x0000_1234, mask=0x0000_FFFF -> rsp rdata=0xFFFF_0000; mem[2]=0xFFFF_1234.
REQ-040 Contention: both valid continuously with writes -> grants alternate 0,1,0,1 starting with 0 after reset; no overlapping strobes.
REQ-041 Lock: cfg_lock=1 -> req_ready=00 for 10 cycles; drop lock -> grant next cycle; lock raised in WAIT -> read still completes.
REQ-042 Errors: op=11, or addr=K with K=48 -> rsp_err=1, no mem strobes; system_rstn low in WAIT -> no rsp_valid, outputs 0 next cycle.
